cardinal_nic_master: RTL and testbench

CARDINAL_NIC_MASTER -- requirements
Module: cardinal_nic_master

---
 rtl/cardinal_nic_pkg.sv | 28 ++
 rtl/cardinal_nic_fifo.sv | 61 ++++++
 rtl/cardinal_nic_master.sv | 162 ++++++++++++++++
 tb/tb_cardinal_nic_master.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cardinal_nic_pkg.sv
// Shared definitions for the cardinal NIC master: NIC register map, status bit
// position and the access FSM encoding.
package cardinal_nic_pkg;

    localparam int unsigned DataWidth = 64;

    localparam logic [1:0] NicAddrInBuf   = 2'd0;
    localparam logic [1:0] NicAddrInStat  = 2'd1;
    localparam logic [1:0] NicAddrOutBuf  = 2'd2;
    localparam logic [1:0] NicAddrOutStat = 2'd3;

    // Index into the NIC's [0:63] data word; bit 63 is the numeric LSB.
    localparam int unsigned StatusFullBit = 63;

    typedef enum logic [2:0] {
        StIdle,
        StPollIn,
        StReadIn,
        StPollOut,
        StWriteOut
    } nic_state_e;

    typedef enum logic {
        SideTx,
        SideRx
    } nic_side_e;

endpackage

// File: rtl/cardinal_nic_fifo.sv
// Synchronous FIFO with wrap-bit pointers; accepts a push while full when a pop
// happens on the same edge.
module cardinal_nic_fifo
    import cardinal_nic_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] PtrOne = 1;

    logic [AddrW:0]         wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]         rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0]   mem_q [Depth];
    logic                   push_en;
    logic                   pop_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);
    assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/cardinal_nic_master.sv
// NIC processor-port initiator: moves client TX packets into the NIC output
// buffer and NIC input-buffer packets into the client RX FIFO.
module cardinal_nic_master
    import cardinal_nic_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_valid,
    input  logic [0:63] tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [0:63] rx_data,
    input  logic        rx_ready,
    output logic [0:1]  nic_addr,
    output logic [0:63] nic_d_out,
    input  logic [0:63] nic_d_in,
    output logic        nicEn,
    output logic        nicWrEn
);

    nic_state_e           state_q, state_d;
    nic_side_e            last_q, last_d;
    logic                 nic_en_q, nic_en_d;
    logic                 nic_wr_en_q, nic_wr_en_d;
    logic [1:0]           nic_addr_q, nic_addr_d;
    logic [DataWidth-1:0] nic_d_out_q, nic_d_out_d;

    logic                 tx_full, tx_empty, tx_pop;
    logic                 rx_full, rx_empty, rx_push;
    logic [DataWidth-1:0] tx_head;
    logic                 status_full;

    cardinal_nic_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (tx_valid && tx_ready),
        .data_i  (tx_data),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    cardinal_nic_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (rx_push),
        .data_i  (nic_d_in),
        .pop_i   (rx_valid && rx_ready),
        .data_o  (rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign tx_ready    = !tx_full;
    assign rx_valid    = !rx_empty;
    assign status_full = nic_d_in[StatusFullBit];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_full && !tx_empty) begin
                    state_d = (last_q == SideRx) ? StPollOut : StPollIn;
                end else if (!rx_full) begin
                    state_d = StPollIn;
                end else if (!tx_empty) begin
                    state_d = StPollOut;
                end
            end
            StPollIn: begin
                if (status_full) begin
                    state_d = StReadIn;
                end else begin
                    state_d = StIdle;
                    last_d  = SideRx;
                end
            end
            StReadIn: begin
                rx_push = 1'b1;
                state_d = StIdle;
                last_d  = SideRx;
            end
            StPollOut: begin
                if (!status_full) begin
                    state_d = StWriteOut;
                end else begin
                    state_d = StIdle;
                    last_d  = SideTx;
                end
            end
            StWriteOut: begin
                tx_pop  = 1'b1;
                state_d = StIdle;
                last_d  = SideTx;
            end
            default: state_d = StIdle;
        endcase

        // NIC strobes are decoded from the next state so they are registered
        // and line up with the cycle the FSM spends in that state.
        nic_en_d    = 1'b0;
        nic_wr_en_d = 1'b0;
        nic_addr_d  = NicAddrInBuf;
        nic_d_out_d = '0;
        unique case (state_d)
            StPollIn: begin
                nic_en_d   = 1'b1;
                nic_addr_d = NicAddrInStat;
            end
            StReadIn: begin
                nic_en_d   = 1'b1;
                nic_addr_d = NicAddrInBuf;
            end
            StPollOut: begin
                nic_en_d   = 1'b1;
                nic_addr_d = NicAddrOutStat;
            end
            StWriteOut: begin
                nic_en_d    = 1'b1;
                nic_wr_en_d = 1'b1;
                nic_addr_d  = NicAddrOutBuf;
                nic_d_out_d = tx_head;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            last_q      <= SideTx;
            nic_en_q    <= 1'b0;
            nic_wr_en_q <= 1'b0;
            nic_addr_q  <= NicAddrInBuf;
            nic_d_out_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            nic_en_q    <= nic_en_d;
            nic_wr_en_q <= nic_wr_en_d;
            nic_addr_q  <= nic_addr_d;
            nic_d_out_q <= nic_d_out_d;
        end
    end

    assign nicEn     = nic_en_q;
    assign nicWrEn   = nic_wr_en_q;
    assign nic_addr  = nic_addr_q;
    assign nic_d_out = nic_d_out_q;

endmodule

// File: tb/tb_cardinal_nic_master.sv
// Scoreboard bench for cardinal_nic_master with a behavioural NIC model.
module tb_cardinal_nic_master;

    localparam int unsigned Depth = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tx_valid = 1'b0;
    logic [0:63] tx_data = '0;
    logic        tx_ready;
    logic        rx_valid;
    logic [0:63] rx_data;
    logic        rx_ready = 1'b0;
    logic [0:1]  nic_addr;
    logic [0:63] nic_d_out;
    logic [0:63] nic_d_in;
    logic        nicEn;
    logic        nicWrEn;

    // NIC model state
    logic        in_full = 1'b0;
    logic        out_full = 1'b0;
    logic        in_fixed = 1'b0;
    logic [63:0] in_buf = 64'h0;
    logic        alt_mode = 1'b0;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int rd_count = 0;
    logic [63:0] tx_exp[$];
    logic [63:0] rx_exp[$];

    always #5 clk = ~clk;

    cardinal_nic_master #(
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .nic_addr  (nic_addr),
        .nic_d_out (nic_d_out),
        .nic_d_in  (nic_d_in),
        .nicEn     (nicEn),
        .nicWrEn   (nicWrEn)
    );

    // Combinational NIC read port; status "full" lives in bit 63 (numeric LSB).
    always_comb begin
        case (nic_addr)
            2'd0:    nic_d_in = in_buf;
            2'd1:    nic_d_in = 64'(in_full);
            2'd3:    nic_d_in = 64'(out_full);
            default: nic_d_in = '0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Monitor: pops the scoreboards and checks NIC protocol every cycle.
    initial begin
        logic       prev_en, prev_wr, prev_stat;
        logic [1:0] prev_addr;
        logic [1:0] prev_poll;
        prev_en = 0; prev_wr = 0; prev_stat = 0; prev_addr = 0; prev_poll = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_en = 0; prev_wr = 0; prev_stat = 0; prev_addr = 0; prev_poll = 0;
            end else begin
                if (!nicEn) begin
                    check("idle_strobes", {61'b0, nicWrEn, nic_addr}, 64'h0);
                    check("idle_d_out", nic_d_out, 64'h0);
                end
                if (nicEn && nicWrEn) begin
                    wr_count++;
                    check("wr_addr", 64'(nic_addr), 64'd2);
                    check("wr_after_poll_out", {59'b0, prev_en, prev_wr, prev_addr, prev_stat},
                          {59'b0, 1'b1, 1'b0, 2'd3, 1'b0});
                    if (tx_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL wr_unexpected: actual=%h required=no write", nic_d_out);
                    end else begin
                        check("tx_order", nic_d_out, tx_exp.pop_front());
                    end
                end
                if (nicEn && !nicWrEn && nic_addr == 2'd0) begin
                    rd_count++;
                    check("rd_after_poll_in", {59'b0, prev_en, prev_wr, prev_addr, prev_stat},
                          {59'b0, 1'b1, 1'b0, 2'd1, 1'b1});
                    rx_exp.push_back(in_buf);
                end
                if (nicEn && !nicWrEn && (nic_addr == 2'd1 || nic_addr == 2'd3)) begin
                    if (alt_mode) begin
                        check("alternate_poll", 64'(nic_addr), (prev_poll == 2'd1) ? 64'd3 : 64'd1);
                    end
                    prev_poll = nic_addr;
                end
                if (rx_valid && rx_ready) begin
                    if (rx_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_unexpected: actual=%h required=no data", rx_data);
                    end else begin
                        check("rx_order", rx_data, rx_exp.pop_front());
                    end
                end
                prev_en   = nicEn;
                prev_wr   = nicWrEn;
                prev_addr = nic_addr;
                prev_stat = nic_d_in[63];
            end
        end
    end

    // NIC input buffer advances to a fresh packet after each read.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && nicEn && !nicWrEn && nic_addr == 2'd0 && !in_fixed) begin
                @(posedge clk);
                #1;
                in_buf = {$urandom, $urandom};
            end
        end
    end

    task automatic tx_send(input logic [63:0] d);
        bit done = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (reset && tx_ready) begin
                tx_exp.push_back(d);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        if (!done) fail_now("tx_accept");
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok = 0;
        @(posedge clk);
        #1;
        in_full  = 1'b0;
        out_full = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            cycles(1);
            ok = (tx_exp.size() == 0) && (rx_exp.size() == 0);
        end
        check("drain_done", 64'(ok), 64'd1);
    endtask

    initial begin
        logic [63:0] pkt;
        int wr0, rd0;
        bit found;
        in_buf = {$urandom, $urandom};

        // Reset values
        #12;
        check("rst_nicEn", 64'(nicEn), 64'd0);
        check("rst_nicWrEn", 64'(nicWrEn), 64'd0);
        check("rst_nic_addr", 64'(nic_addr), 64'd0);
        check("rst_nic_d_out", nic_d_out, 64'h0);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);

        // Both sides eligible from the first cycle: polls alternate, RX first
        in_full  = 1'b1;
        out_full = 1'b0;
        rx_ready = 1'b1;
        alt_mode = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tx_send({$urandom, $urandom});
        alt_mode = 1'b0;
        drain();

        // Best-case TX latency: push on the edge leaving a POLL_IN cycle
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = nicEn && !nicWrEn && nic_addr == 2'd1;
        end
        if (!found) begin
            fail_now("sync_poll_in");
        end else begin
            pkt = 64'hDEAD_BEEF_0000_0001;
            tx_valid = 1'b1;
            tx_data  = pkt;
            tx_exp.push_back(pkt);
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            @(negedge clk);
            check("lat_idle_en", 64'(nicEn), 64'd0);
            @(negedge clk);
            check("lat_poll_out", {61'b0, nicEn, nicWrEn, 1'b0}, {61'b0, 1'b1, 1'b0, 1'b0});
            check("lat_poll_addr", 64'(nic_addr), 64'd3);
            @(negedge clk);
            check("lat_wr_strobe", {62'b0, nicEn, nicWrEn}, 64'd3);
            check("lat_wr_addr", 64'(nic_addr), 64'd2);
            check("lat_wr_data", nic_d_out, pkt);
        end
        drain();

        // Output buffer full: TX fills, no writes until status releases
        out_full = 1'b1;
        wr0 = wr_count;
        for (int i = 0; i < 4; i++) tx_send(64'hA000_0000_0000_0000 + 64'(i));
        @(negedge clk);
        check("tx_full_ready", 64'(tx_ready), 64'd0);
        cycles(10);
        check("tx_blocked_writes", 64'(wr_count - wr0), 64'd0);
        out_full = 1'b0;
        tx_send(64'hA000_0000_0000_0004);
        drain();
        check("tx_release_writes", 64'(wr_count - wr0), 64'd5);

        // RX backpressure: exactly Depth reads, then none until the client pops
        in_fixed = 1'b1;
        in_buf   = 64'h0123_4567_89AB_CDEF;
        rx_ready = 1'b0;
        in_full  = 1'b1;
        rd0 = rd_count;
        cycles(40);
        check("rx_full_reads", 64'(rd_count - rd0), 64'(Depth));
        check("rx_full_queue", 64'(rx_exp.size()), 64'(Depth));
        @(negedge clk);
        check("rx_valid_full", 64'(rx_valid), 64'd1);
        check("rx_head_full", rx_data, 64'h0123_4567_89AB_CDEF);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        cycles(20);
        check("rx_resumed", 64'(rd_count - rd0 > int'(Depth)), 64'd1);
        drain();
        in_fixed = 1'b0;

        // Randomised traffic with toggling status and client backpressure
        begin
            bit rand_on = 1;
            fork
                begin
                    for (int i = 0; i < 40; i++) begin
                        tx_send({$urandom, $urandom});
                        cycles($urandom_range(0, 3));
                    end
                    rand_on = 0;
                end
                begin
                    while (rand_on) begin
                        @(posedge clk);
                        #1;
                        out_full = ($urandom_range(0, 3) == 0);
                        in_full  = 1'($urandom_range(0, 1));
                        rx_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            join
        end
        drain();

        // Reset in the middle of WRITE_OUT
        out_full = 1'b1;
        for (int i = 0; i < 3; i++) tx_send(64'hC000_0000_0000_0000 + 64'(i));
        out_full = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            found = nicWrEn;
        end
        if (!found) begin
            fail_now("wait_write_out");
        end else begin
            #2;
            reset = 1'b0;
            #1;
            check("mid_rst_strobes", {62'b0, nicEn, nicWrEn}, 64'd0);
            check("mid_rst_addr", 64'(nic_addr), 64'd0);
            check("mid_rst_d_out", nic_d_out, 64'h0);
            check("mid_rst_tx_ready", 64'(tx_ready), 64'd1);
            check("mid_rst_rx_valid", 64'(rx_valid), 64'd0);
            tx_exp.delete();
            rx_exp.delete();
            wr0 = wr_count;
            cycles(2);
            reset = 1'b1;
            cycles(15);
            check("post_rst_writes", 64'(wr_count - wr0), 64'd0);
            @(negedge clk);
            check("post_rst_tx_ready", 64'(tx_ready), 64'd1);
            check("post_rst_rx_valid", 64'(rx_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
